// File: rtl/wb_unit_if.sv
// Writeback unit bus: four result lanes in, two register-file
// write ports plus decoder status out.
interface wb_unit_if #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          a1_v;
  logic [RW-1:0] a1_rd;
  logic [DW-1:0] a1_d;
  logic          a2_v;
  logic [RW-1:0] a2_rd;
  logic [DW-1:0] a2_d;
  logic          m1_v;
  logic [RW-1:0] m1_rd;
  logic [DW-1:0] m1_d;
  logic          m2_v;
  logic [RW-1:0] m2_rd;
  logic [DW-1:0] m2_d;

  logic          wa_en;
  logic [RW-1:0] wa_rd;
  logic [DW-1:0] wa_d;
  logic          wb_en;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_d;
  logic          stall;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output a1_v, a1_rd, a1_d,
    output a2_v, a2_rd, a2_d,
    output m1_v, m1_rd, m1_d,
    output m2_v, m2_rd, m2_d,
    input  wa_en, wa_rd, wa_d,
    input  wb_en, wb_rd, wb_d,
    input  stall, count, overflow
  );

  modport slave (
    input  a1_v, a1_rd, a1_d,
    input  a2_v, a2_rd, a2_d,
    input  m1_v, m1_rd, m1_d,
    input  m2_v, m2_rd, m2_d,
    output wa_en, wa_rd, wa_d,
    output wb_en, wb_rd, wb_d,
    output stall, count, overflow
  );
endinterface

// File: rtl/wb_unit.sv
// Register-file writeback unit: in-order FIFO taking up to four
// results per cycle and retiring up to two on the write ports.
module wb_unit #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  wb_unit_if.slave  io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;
  ent_t          hola_q, hola_d;
  ent_t          holb_q, holb_d;

  ent_t          in_e [4];
  logic [3:0]    in_v;
  ent_t          h0, h1;
  ent_t          a_sel, b_sel;
  logic          two, same;
  logic [2:0]    npush;
  logic [1:0]    npop;
  logic [CW-1:0] free;

  assign h0   = mem_q[rp_q];
  assign h1   = mem_q[rp_q + PW'(1)];
  assign two  = cnt_q >= CW'(2);
  assign same = h0.rd == h1.rd;

  // r0 writes are dropped before they reach the FIFO
  always_comb begin
    in_e[0] = {io.a1_rd, io.a1_d};
    in_e[1] = {io.a2_rd, io.a2_d};
    in_e[2] = {io.m1_rd, io.m1_d};
    in_e[3] = {io.m2_rd, io.m2_d};
    in_v[0] = io.a1_v && |io.a1_rd;
    in_v[1] = io.a2_v && |io.a2_rd;
    in_v[2] = io.m1_v && |io.m1_rd;
    in_v[3] = io.m2_v && |io.m2_rd;
  end

  always_comb begin
    io.wa_en = 1'b0;
    io.wb_en = 1'b0;
    a_sel    = hola_q;
    b_sel    = holb_q;
    npop     = 2'd0;
    if (two) begin
      a_sel    = h0;
      b_sel    = h1;
      io.wa_en = !same;
      io.wb_en = 1'b1;
      npop     = 2'd2;
    end else if (cnt_q != '0) begin
      a_sel    = h0;
      io.wa_en = 1'b1;
      npop     = 2'd1;
    end
    io.wa_rd = a_sel.rd;
    io.wa_d  = a_sel.d;
    io.wb_rd = b_sel.rd;
    io.wb_d  = b_sel.d;
    hola_d   = a_sel;
    holb_d   = b_sel;
  end

  // free space uses start-of-cycle count; pops do not help
  always_comb begin
    mem_d = mem_q;
    npush = 3'd0;
    ovf_d = ovf_q;
    free  = CW'(DEPTH) - cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (in_v[i]) begin
        if (CW'(npush) < free) begin
          mem_d[wp_q + PW'(npush)] = in_e[i];
          npush = npush + 3'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    cnt_d   = cnt_q + CW'(npush) - CW'(npop);
    wp_d    = wp_q + PW'(npush);
    rp_d    = rp_q + PW'(npop);
    stall_d = cnt_d > CW'(DEPTH - 4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rp_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      hola_q  <= '0;
      holb_q  <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
      hola_q  <= hola_d;
      holb_q  <= holb_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign io.stall    = stall_q;
  assign io.overflow = ovf_q;
  assign io.count    = cnt_q;
endmodule
